mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory (256 x 32) between three requesters: MEM-stage load/store (port D), instruction fetch (port F), and the external loader/debug port (port X).
- Sits between the pipeline stages and the memory array. It replaces direct array indexing from the fetch and memory stages.
- Policy: fixed priority for D, round-robin between F and X, a starvation guard for F, and an exclusive lock mode for X bursts.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive denied fetch cycles before F is promoted above D (range 1..15).

Ports:
- clk1  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- d_req, f_req, x_req  in  1 each  access request, held until granted.
- d_we, x_we  in  1 each  write enable (F is read-only).
- d_addr, f_addr, x_addr  in  ADDR_W each  word address.
- d_wdata, x_wdata  in  DATA_W each  write data.
- x_lock  in  1  X requests exclusive ownership across consecutive accesses.
- d_gnt, f_gnt, x_gnt  out  1 each  grant; combinational, same cycle as the winning request.
- d_rvalid, f_rvalid, x_rvalid  out  1 each  read data valid; one-cycle pulse, one cycle after a granted read.
- rdata  out  DATA_W  read data, valid only while an rvalid is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; 1-cycle latency after mem_en with mem_we=0.
- lock_active  out  1  high while the FSM is in LOCK.

Behaviour:
- Reset state: all gnt=0, all rvalid=0, mem_en=0, mem_we=0, lock_active=0.
- Reset also sets FSM=RUN, fetch wait counter=0, and the RR pointer to favour F.
- Reset takes priority over every other event, including mid-LOCK and pending read returns; the pending rvalid is suppressed.
- At most one grant per cycle.
- mem_en, mem_we, mem_addr and mem_wdata are muxed from the winner. With no winner, mem_en=0 and mem_we=0.
- FSM RUN arbitration order:
  1. F, if wait_cnt==MAX_WAIT.
  2. D.
  3. Round-robin between F and X: pointer favours the requester not granted last among {F,X}. The pointer updates only on an F or X grant.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle f_req=1 and f_gnt=0. Clears on f_gnt or when f_req=0.
- RUN -> LOCK: on a cycle with x_gnt=1 and x_lock=1. Takes effect the next cycle.
- FSM LOCK:
  - Only X may be granted (x_gnt=x_req). D and F are stalled.
  - wait_cnt still counts but has no effect in LOCK.
  - LOCK -> RUN when x_lock=0 is sampled. The same cycle is still arbitrated as LOCK, so X is granted if x_req=1; RUN arbitration applies from the next cycle.
- Read return:
  - A granted read registers the owner ID.
  - The next cycle, that port's rvalid=1 and rdata=mem_rdata.
  - A new grant may issue in the same cycle as a return, giving back-to-back throughput of one access per cycle.
- Writes produce no rvalid.
- Simultaneous read-after-write to the same address in consecutive cycles returns the newly written data; this is a memory property, and the arbiter does not forward.
- Requester rule: req, we, addr and wdata stay stable until gnt. Dropping req before gnt is legal and is a no-op.

Test Plan:
- Reset, then d_req=1 (read, addr 0x10) with f_req=1 (addr 0x00) in the same cycle -> d_gnt=1, f_gnt=0. Next cycle d_rvalid=1, rdata=mem[0x10]; f_gnt=1 that cycle if d_req has dropped.
- d_req held high continuously with f_req=1, MAX_WAIT=4 -> f denied 4 cycles, f_gnt=1 on the 5th cycle, d_gnt=0 that cycle; wait_cnt returns to 0.
- f_req and x_req both high, d_req=0, for 4 cycles -> grants alternate F,X,F,X starting with F after reset.
- x_req=1, x_lock=1, x_we=1, writes to addr 0x20..0x23 while d_req=1 -> lock_active=1 from the cycle after the first x_gnt. d_gnt=0 throughout LOCK. After x_lock=0 is sampled, d_gnt=1 on the next cycle.
- Assert reset during LOCK, one cycle after an X read grant -> x_rvalid stays 0; lock_active=0, all gnt=0 and mem_en=0 while reset is high. After release, RUN arbitration applies with F favoured.
- d_we=1 writes 0xDEADBEEF to addr 0x05, then f_req reads addr 0x05 -> f_rvalid=1 with rdata=0xDEADBEEF, and no d_rvalid for the write.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every signal between the three memory requesters (D = MEM-stage
//   load/store, F = instruction fetch, X = external loader/debug), the shared
//   single-port memory array and the arbiter.
//
//   modport master : requester/memory side (drives requests and mem_rdata,
//                    observes grants, read returns and memory strobes)
//   modport slave  : arbiter side
//
//   Signal summary
//     d_req/f_req/x_req     request, held until granted
//     d_we/x_we             write enable (F is read-only)
//     d_addr/f_addr/x_addr  word address
//     d_wdata/x_wdata       write data
//     x_lock                X asks for exclusive ownership over a burst
//     d_gnt/f_gnt/x_gnt     combinational grant
//     d_rvalid/f_rvalid/x_rvalid  one-cycle read-return pulse
//     rdata                 read data, meaningful only with an rvalid
//     mem_en/mem_we/mem_addr/mem_wdata  memory strobes from the winner
//     mem_rdata             memory read data, one cycle after a read strobe
//     lock_active           arbiter is in the exclusive X mode
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              d_req;
  logic              f_req;
  logic              x_req;
  logic              d_we;
  logic              x_we;
  logic [ADDR_W-1:0] d_addr;
  logic [ADDR_W-1:0] f_addr;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] x_wdata;
  logic              x_lock;

  logic              d_gnt;
  logic              f_gnt;
  logic              x_gnt;
  logic              d_rvalid;
  logic              f_rvalid;
  logic              x_rvalid;
  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              lock_active;

  modport master (
    output d_req, f_req, x_req, d_we, x_we,
    output d_addr, f_addr, x_addr, d_wdata, x_wdata, x_lock,
    input  d_gnt, f_gnt, x_gnt, d_rvalid, f_rvalid, x_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  lock_active
  );

  modport slave (
    input  d_req, f_req, x_req, d_we, x_we,
    input  d_addr, f_addr, x_addr, d_wdata, x_wdata, x_lock,
    output d_gnt, f_gnt, x_gnt, d_rvalid, f_rvalid, x_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output lock_active
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-port unified instruction/data memory between the
//   MEM-stage port (D), instruction fetch (F) and the loader/debug port (X).
//
//   Policy in RUN:
//     1. F when it has been denied MAX_WAIT consecutive cycles (starvation)
//     2. D
//     3. F/X round-robin; the pointer favours whichever of F/X was not
//        granted last and only moves on an F or X grant
//   LOCK: only X is served; entered after an X grant with x_lock=1, left
//   once x_lock=0 is sampled (that cycle is still arbitrated as LOCK).
//
//   Ports
//     clk1    clock
//     reset   synchronous, active-high reset
//     arb_if  requester / memory bundle (slave view)
//
//   State table
//     ST_RUN  | normal priority + round-robin arbitration
//     ST_LOCK | exclusive X burst, D and F stalled
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk1,
  input  logic              reset,
  mem_port_arbiter_if.slave arb_if
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [3:0]        WAIT_MAX   = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

  state_t     state_q;
  logic [3:0] wait_q;
  logic [3:0] wait_d;
  logic       rr_fav_x_q;
  logic       rr_fav_x_d;
  logic       d_rvalid_q;
  logic       f_rvalid_q;
  logic       x_rvalid_q;

  logic       d_win;
  logic       f_win;
  logic       x_win;
  logic       f_starved;

  assign f_starved = (wait_q == WAIT_MAX);

  // Grant selection. Reset masks every grant so no memory access or read
  // return can be launched while the block is being reset.
  always_comb begin
    d_win = 1'b0;
    f_win = 1'b0;
    x_win = 1'b0;
    if (!reset) begin
      if (state_q == ST_LOCK) begin
        x_win = arb_if.x_req;
      end else if (arb_if.f_req && f_starved) begin
        f_win = 1'b1;
      end else if (arb_if.d_req) begin
        d_win = 1'b1;
      end else if (arb_if.f_req && arb_if.x_req) begin
        if (rr_fav_x_q) begin
          x_win = 1'b1;
        end else begin
          f_win = 1'b1;
        end
      end else if (arb_if.f_req) begin
        f_win = 1'b1;
      end else if (arb_if.x_req) begin
        x_win = 1'b1;
      end
    end
  end

  // Memory strobe mux; F never writes so it contributes no write data.
  always_comb begin
    arb_if.mem_en    = d_win | f_win | x_win;
    arb_if.mem_we    = 1'b0;
    arb_if.mem_addr  = ADDR_ZERO;
    arb_if.mem_wdata = DATA_ZERO;
    if (d_win) begin
      arb_if.mem_we    = arb_if.d_we;
      arb_if.mem_addr  = arb_if.d_addr;
      arb_if.mem_wdata = arb_if.d_wdata;
    end else if (f_win) begin
      arb_if.mem_addr  = arb_if.f_addr;
    end else if (x_win) begin
      arb_if.mem_we    = arb_if.x_we;
      arb_if.mem_addr  = arb_if.x_addr;
      arb_if.mem_wdata = arb_if.x_wdata;
    end
  end

  // Fetch wait counter keeps counting in LOCK (saturating), so a fetch that
  // waited out a burst is promoted as soon as RUN resumes.
  always_comb begin
    wait_d = 4'd0;
    if (arb_if.f_req && !f_win) begin
      wait_d = f_starved ? wait_q : wait_q + 4'd1;
    end
  end

  always_comb begin
    rr_fav_x_d = rr_fav_x_q;
    if (f_win) begin
      rr_fav_x_d = 1'b1;
    end else if (x_win) begin
      rr_fav_x_d = 1'b0;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_q     <= 4'd0;
      rr_fav_x_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rvalid_q <= 1'b0;
      x_rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (x_win && arb_if.x_lock) begin
            state_q <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (!arb_if.x_lock) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
      wait_q     <= wait_d;
      rr_fav_x_q <= rr_fav_x_d;
      // Owner of the read in flight; the memory returns data next cycle.
      d_rvalid_q <= d_win & ~arb_if.d_we;
      f_rvalid_q <= f_win;
      x_rvalid_q <= x_win & ~arb_if.x_we;
    end
  end

  assign arb_if.d_gnt = d_win;
  assign arb_if.f_gnt = f_win;
  assign arb_if.x_gnt = x_win;

  // A read granted the cycle before reset rises must not return while reset
  // is high, hence the gating on top of the registered owner flags.
  assign arb_if.d_rvalid    = d_rvalid_q & ~reset;
  assign arb_if.f_rvalid    = f_rvalid_q & ~reset;
  assign arb_if.x_rvalid    = x_rvalid_q & ~reset;
  assign arb_if.rdata       = arb_if.mem_rdata;
  assign arb_if.lock_active = (state_q == ST_LOCK) & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  localparam int W_D    = 0;
  localparam int W_F    = 1;
  localparam int W_X    = 2;
  localparam int W_NONE = 3;

  logic clk1 = 1'b0;
  logic reset = 1'b1;
  always #5 clk1 = ~clk1;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk1  (clk1),
    .reset (reset),
    .arb_if(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return 32'h1000_0000 | {24'd0, a};
  endfunction

  // Memory array: unwritten words read back as init_val(addr).
  logic [31:0] mem_arr [256];
  bit          mem_wr  [256];
  initial bus.mem_rdata = 32'd0;
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem_arr[bus.mem_addr] <= bus.mem_wdata;
        mem_wr[bus.mem_addr]  <= 1'b1;
      end else begin
        bus.mem_rdata <= mem_wr[bus.mem_addr] ? mem_arr[bus.mem_addr] : init_val(bus.mem_addr);
      end
    end
  end

  // Reference model of the arbitration rules
  bit          m_lock   = 1'b0;
  int          m_wait   = 0;
  bit          m_fav_f  = 1'b1;
  int          m_pend   = W_NONE;
  logic [31:0] m_pend_data = 32'd0;
  logic [31:0] shadow   [256];
  bit          shadow_wr[256];

  int          c_w;
  logic        c_we;
  logic [7:0]  c_a;
  logic [31:0] c_wd;

  always @(negedge clk1) begin
    c_w = W_NONE;
    if (!reset) begin
      if (m_lock) begin
        if (bus.x_req) c_w = W_X;
      end else if (bus.f_req && m_wait >= MAX_WAIT) c_w = W_F;
      else if (bus.d_req) c_w = W_D;
      else if (bus.f_req && bus.x_req) c_w = m_fav_f ? W_F : W_X;
      else if (bus.f_req) c_w = W_F;
      else if (bus.x_req) c_w = W_X;
    end
    c_we = 1'b0; c_a = 8'd0; c_wd = 32'd0;
    case (c_w)
      W_D: begin c_we = bus.d_we; c_a = bus.d_addr; c_wd = bus.d_wdata; end
      W_F: begin c_we = 1'b0;     c_a = bus.f_addr; end
      W_X: begin c_we = bus.x_we; c_a = bus.x_addr; c_wd = bus.x_wdata; end
      default: ;
    endcase

    chk("d_gnt", 32'(bus.d_gnt), 32'(c_w == W_D));
    chk("f_gnt", 32'(bus.f_gnt), 32'(c_w == W_F));
    chk("x_gnt", 32'(bus.x_gnt), 32'(c_w == W_X));
    chk("mem_en", 32'(bus.mem_en), 32'(c_w != W_NONE));
    if (c_w != W_NONE) begin
      chk("mem_we", 32'(bus.mem_we), 32'(c_we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(c_a));
      if (c_we) chk("mem_wdata", bus.mem_wdata, c_wd);
    end else begin
      chk("mem_we_idle", 32'(bus.mem_we), 32'd0);
    end
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(!reset && m_pend == W_D));
    chk("f_rvalid", 32'(bus.f_rvalid), 32'(!reset && m_pend == W_F));
    chk("x_rvalid", 32'(bus.x_rvalid), 32'(!reset && m_pend == W_X));
    if (!reset && m_pend != W_NONE) chk("rdata", bus.rdata, m_pend_data);
    chk("lock_active", 32'(bus.lock_active), 32'(m_lock && !reset));

    if (reset) begin
      m_lock  = 1'b0;
      m_wait  = 0;
      m_fav_f = 1'b1;
      m_pend  = W_NONE;
    end else begin
      m_pend = W_NONE;
      if (c_w != W_NONE) begin
        if (c_we) begin
          shadow[c_a]    = c_wd;
          shadow_wr[c_a] = 1'b1;
        end else begin
          m_pend      = c_w;
          m_pend_data = shadow_wr[c_a] ? shadow[c_a] : init_val(c_a);
        end
      end
      if (bus.f_req && c_w != W_F) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      if (c_w == W_F) m_fav_f = 1'b0;
      if (c_w == W_X) m_fav_f = 1'b1;
      if (m_lock) begin
        if (!bus.x_lock) m_lock = 1'b0;
      end else if (c_w == W_X && bus.x_lock) begin
        m_lock = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk1);
  endtask

  task automatic idle_inputs();
    bus.d_req = 1'b0; bus.f_req = 1'b0; bus.x_req = 1'b0;
    bus.d_we = 1'b0;  bus.x_we = 1'b0;  bus.x_lock = 1'b0;
    bus.d_addr = 8'd0; bus.f_addr = 8'd0; bus.x_addr = 8'd0;
    bus.d_wdata = 32'd0; bus.x_wdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    bus.d_req = 1'b1; bus.f_req = 1'b1; bus.x_req = 1'b1;
    at_neg();
    step();
    at_neg();
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("rst_x_gnt", 32'(bus.x_gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_lock", 32'(bus.lock_active), 32'd0);
    step();

    // D beats F, then F follows once D drops
    idle_inputs();
    reset = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = 8'h10;
    bus.f_req = 1'b1; bus.f_addr = 8'h00;
    at_neg();
    chk("p1_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("p1_f_gnt", 32'(bus.f_gnt), 32'd0);
    step();
    bus.d_req = 1'b0;
    at_neg();
    chk("p1_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("p1_rdata_d", bus.rdata, 32'h1000_0010);
    chk("p1_f_gnt2", 32'(bus.f_gnt), 32'd1);
    step();
    bus.f_req = 1'b0;
    at_neg();
    chk("p1_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("p1_rdata_f", bus.rdata, 32'h1000_0000);
    step();

    // Starvation guard: F promoted on its fifth requesting cycle
    bus.d_req = 1'b1; bus.d_addr = 8'h02;
    bus.f_req = 1'b1; bus.f_addr = 8'h01;
    for (int k = 1; k <= 4; k++) begin
      at_neg();
      chk("p2_d_gnt", 32'(bus.d_gnt), 32'd1);
      chk("p2_f_gnt", 32'(bus.f_gnt), 32'd0);
      step();
    end
    at_neg();
    chk("p2_f_promoted", 32'(bus.f_gnt), 32'd1);
    chk("p2_d_stalled", 32'(bus.d_gnt), 32'd0);
    step();
    bus.f_req = 1'b0;
    at_neg();
    chk("p2_d_again", 32'(bus.d_gnt), 32'd1);
    step();
    bus.d_req = 1'b0;
    at_neg();
    step();

    // Round-robin F/X after reset starts with F
    reset = 1'b1;
    at_neg();
    step();
    reset = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 8'h03;
    bus.x_req = 1'b1; bus.x_addr = 8'h04;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("p3_rr_f", 32'(bus.f_gnt), 32'(k % 2 == 0));
      chk("p3_rr_x", 32'(bus.x_gnt), 32'(k % 2 == 1));
      step();
    end
    bus.f_req = 1'b0; bus.x_req = 1'b0;
    at_neg();
    step();

    // X lock burst writes 0x20..0x23 while D waits
    bus.x_req = 1'b1; bus.x_lock = 1'b1; bus.x_we = 1'b1;
    bus.x_addr = 8'h20; bus.x_wdata = 32'hC0DE_0020;
    at_neg();
    chk("p4_x_gnt0", 32'(bus.x_gnt), 32'd1);
    chk("p4_lock0", 32'(bus.lock_active), 32'd0);
    step();
    for (int i = 1; i <= 3; i++) begin
      bus.x_addr = 8'(8'h20 + i);
      bus.x_wdata = 32'hC0DE_0020 + 32'(i);
      bus.d_req = 1'b1; bus.d_addr = 8'h30;
      if (i == 3) bus.x_lock = 1'b0;
      at_neg();
      chk("p4_lock", 32'(bus.lock_active), 32'd1);
      chk("p4_x_gnt", 32'(bus.x_gnt), 32'd1);
      chk("p4_d_stall", 32'(bus.d_gnt), 32'd0);
      step();
    end
    bus.x_req = 1'b0; bus.x_we = 1'b0;
    at_neg();
    chk("p4_d_after", 32'(bus.d_gnt), 32'd1);
    chk("p4_unlock", 32'(bus.lock_active), 32'd0);
    step();
    bus.d_req = 1'b0;
    at_neg();
    step();

    // Reset during LOCK right after an X read grant
    bus.x_req = 1'b1; bus.x_lock = 1'b1; bus.x_we = 1'b0; bus.x_addr = 8'h21;
    at_neg();
    chk("p5_x_gnt", 32'(bus.x_gnt), 32'd1);
    step();
    bus.x_addr = 8'h22;
    at_neg();
    chk("p5_lock", 32'(bus.lock_active), 32'd1);
    chk("p5_x_rvalid", 32'(bus.x_rvalid), 32'd1);
    chk("p5_rdata", bus.rdata, 32'hC0DE_0021);
    step();
    reset = 1'b1;
    bus.d_req = 1'b1; bus.f_req = 1'b1; bus.f_addr = 8'h06;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("p5_rst_x_rvalid", 32'(bus.x_rvalid), 32'd0);
      chk("p5_rst_lock", 32'(bus.lock_active), 32'd0);
      chk("p5_rst_gnts", 32'({bus.d_gnt, bus.f_gnt, bus.x_gnt}), 32'd0);
      chk("p5_rst_mem_en", 32'(bus.mem_en), 32'd0);
      step();
    end
    reset = 1'b0;
    bus.d_req = 1'b0; bus.x_lock = 1'b0;
    at_neg();
    chk("p5_rel_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("p5_rel_x_gnt", 32'(bus.x_gnt), 32'd0);
    step();
    bus.f_req = 1'b0;
    at_neg();
    chk("p5_rel_x_next", 32'(bus.x_gnt), 32'd1);
    step();
    bus.x_req = 1'b0;
    at_neg();
    step();

    // D write then F read of the same word
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h05; bus.d_wdata = 32'hDEAD_BEEF;
    at_neg();
    chk("p6_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("p6_mem_we", 32'(bus.mem_we), 32'd1);
    step();
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 8'h05;
    at_neg();
    chk("p6_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("p6_no_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    step();
    bus.f_req = 1'b0;
    at_neg();
    chk("p6_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("p6_rdata", bus.rdata, 32'hDEAD_BEEF);
    step();

    // F withdraws before being granted: nothing happens for it
    bus.d_req = 1'b1; bus.d_addr = 8'h07;
    bus.f_req = 1'b1; bus.f_addr = 8'h08;
    at_neg();
    step();
    bus.d_req = 1'b0; bus.f_req = 1'b0;
    at_neg();
    chk("p7_no_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("p7_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    step();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
